// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control slice.
// The FSM state encoding here is also the encoding of the debug state port.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  // Rate of the count strobe arriving on the tick input.
  localparam int TICK_HZ = 10;

  // States in which the digit counter advances on tick.
  function automatic logic is_counting(input sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-counter debounce and
// a one-clk press pulse on the debounced released->pressed transition.
// A button already held when reset releases is ignored until it has been
// seen released at least once (armed_q).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n,
  output logic press,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             level_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_s;
  logic             accept;

  assign btn_s  = sync_q[1];
  assign accept = (btn_s != level_q) && (cnt_q == CNT_LAST);
  assign held   = armed_q & ~level_q;

  // Synchronize, time level stability, update debounced level and emit press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button_n};
      // fill_q[1] marks that btn_s now reflects a real sample, not reset fill.
      fill_q <= {fill_q[0], 1'b1};
      if (btn_s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= btn_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      armed_q <= armed_q | (fill_q[1] & btn_s & level_q);
      press   <= armed_q & accept & ~btn_s;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: debounced start/stop and lap/clear buttons
// drive an IDLE/RUN/LAP/STOP FSM that gates the tick into count_en, issues
// count_clr pulses and freezes the display during LAP.
// Optional build macro STOPWATCH_LONG_PRESS_CLEAR_EN: holding the start button
// for LONG_PRESS_CYCLES clears the stopwatch from any state.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 200000000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      button_n,
  input  logic      lap_n,
  input  logic      tick,
  output logic      count_en,
  output logic      count_clr,
  output logic      display_hold,
  output logic      running,
  output sw_state_t state
);

  sw_state_t state_q;
  sw_state_t state_next;
  logic      clr_evt;
  logic      start_evt;
  logic      lap_evt;
  logic      start_held;
  logic      lap_held;
  logic      long_evt;
  logic      unused_ok;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk      (clk),
    .reset_n  (reset_n),
    .button_n (button_n),
    .press    (start_evt),
    .held     (start_held)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk      (clk),
    .reset_n  (reset_n),
    .button_n (lap_n),
    .press    (lap_evt),
    .held     (lap_held)
  );

`ifdef STOPWATCH_LONG_PRESS_CLEAR_EN
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);

  logic [LP_W-1:0] lp_cnt_q;

  // Fires on the LONG_PRESS_CYCLES-th consecutive held cycle only.
  assign long_evt = start_held && (lp_cnt_q == LP_MAX - LP_W'(1));

  // Time continuous debounced start press; saturate so one hold clears once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp_cnt_q <= '0;
    end else if (!start_held) begin
      lp_cnt_q <= '0;
    end else if (lp_cnt_q != LP_MAX) begin
      lp_cnt_q <= lp_cnt_q + LP_W'(1);
    end
  end

  // Lap level is not needed here; TICK_HZ only documents the tick rate.
  assign unused_ok = ^{lap_held, TICK_HZ[0]};
`else
  assign long_evt  = 1'b0;
  // Held levels and LONG_PRESS_CYCLES feed only the long-press timer.
  assign unused_ok = ^{start_held, lap_held, LONG_PRESS_CYCLES[0], TICK_HZ[0]};
`endif

  // Next-state and clear-event decode; start has priority over lap.
  always_comb begin
    state_next = state_q;
    clr_evt    = 1'b0;
    if (start_evt) begin
      case (state_q)
        IDLE:    state_next = RUN;
        RUN:     state_next = STOP;
        LAP:     state_next = STOP;
        STOP:    state_next = RUN;
        default: state_next = IDLE;
      endcase
    end else if (lap_evt) begin
      case (state_q)
        IDLE: clr_evt = 1'b1;
        RUN:  state_next = LAP;
        LAP:  state_next = RUN;
        STOP: begin
          state_next = IDLE;
          clr_evt    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
    if (long_evt) begin
      state_next = IDLE;
      clr_evt    = 1'b1;
    end
  end

  // State register; status outputs are registered from the next state so
  // they always agree with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_clr    <= 1'b0;
      display_hold <= 1'b0;
      running      <= 1'b0;
    end else begin
      state_q      <= state_next;
      count_clr    <= clr_evt;
      display_hold <= (state_next == LAP);
      running      <= is_counting(state_next);
    end
  end

  // Tick gating uses the current (pre-transition) state.
  assign count_en = tick & is_counting(state_q);
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int N   = 4;
  localparam int LP  = 50;
  localparam int LAT = N + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       button_n;
  logic       lap_n;
  logic       tick;
  logic       count_en;
  logic       count_clr;
  logic       display_hold;
  logic       running;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(N), .LONG_PRESS_CYCLES(LP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_n     (button_n),
    .lap_n        (lap_n),
    .tick         (tick),
    .count_en     (count_en),
    .count_clr    (count_clr),
    .display_hold (display_hold),
    .running      (running),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Driver: assert buttons at a falling edge, return at the falling edge
  // just after the FSM has taken the resulting event.
  task automatic press_begin(input logic s, input logic l);
    button_n = ~s;
    lap_n    = ~l;
    repeat (LAT) @(negedge clk);
  endtask

  // Driver: hold a little longer, release, let the release debounce out.
  task automatic press_end();
    repeat (3) @(negedge clk);
    button_n = 1'b1;
    lap_n    = 1'b1;
    repeat (N + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    button_n = 1'b1;
    lap_n    = 1'b1;
    tick     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL reset_count_clr got=%b exp=0", count_clr); end
    checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", display_hold); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    tick = 1'b1; #1;
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL reset_count_en got=%b exp=0", count_en); end
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic test_start();
    button_n = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL start_early got=%0d exp=%0d", state, IDLE); end
    @(negedge clk);
    checks++; if (state !== RUN) begin errors++; $display("FAIL start_run got=%0d exp=%0d", state, RUN); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got=%b exp=1", running); end
    repeat (20 - LAT) @(negedge clk);
    checks++; if (state !== RUN) begin errors++; $display("FAIL start_held_once got=%0d exp=%0d", state, RUN); end
    button_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic exp_en;
      exp_en = (i % 10 == 0);
      tick = exp_en; #1;
      checks++; if (count_en !== exp_en) begin errors++; $display("FAIL run_count_en[%0d] got=%b exp=%b", i, count_en, exp_en); end
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 12; c++) begin
      button_n = logic'((c / 2) % 2);
      @(negedge clk);
      checks++; if (state !== RUN) begin errors++; $display("FAIL bounce_no_event[%0d] got=%0d exp=%0d", c, state, RUN); end
    end
    button_n = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    checks++; if (state !== RUN) begin errors++; $display("FAIL bounce_early got=%0d exp=%0d", state, RUN); end
    @(negedge clk);
    checks++; if (state !== STOP) begin errors++; $display("FAIL bounce_stop got=%0d exp=%0d", state, STOP); end
    press_end();
    for (int i = 0; i < 20; i++) begin
      tick = (i % 10 == 0); #1;
      if (tick) begin
        checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL stop_count_en[%0d] got=%b exp=0", i, count_en); end
      end
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic test_lap();
    press_begin(1'b1, 1'b0);
    checks++; if (state !== RUN) begin errors++; $display("FAIL lap_pre_run got=%0d exp=%0d", state, RUN); end
    press_end();
    press_begin(1'b0, 1'b1);
    checks++; if (state !== LAP) begin errors++; $display("FAIL lap_state got=%0d exp=%0d", state, LAP); end
    checks++; if (display_hold !== 1'b1) begin errors++; $display("FAIL lap_hold got=%b exp=1", display_hold); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running got=%b exp=1", running); end
    press_end();
    for (int i = 0; i < 10; i++) begin
      logic exp_en;
      exp_en = (i == 0);
      tick = exp_en; #1;
      checks++; if (count_en !== exp_en) begin errors++; $display("FAIL lap_count_en[%0d] got=%b exp=%b", i, count_en, exp_en); end
      @(negedge clk);
    end
    tick = 1'b0;
    press_begin(1'b0, 1'b1);
    checks++; if (state !== RUN) begin errors++; $display("FAIL lap_back_run got=%0d exp=%0d", state, RUN); end
    checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL lap_unhold got=%b exp=0", display_hold); end
    press_end();
  endtask

  task automatic test_clear();
    press_begin(1'b1, 1'b0);
    checks++; if (state !== STOP) begin errors++; $display("FAIL clr_pre_stop got=%0d exp=%0d", state, STOP); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL clr_none_on_stop got=%b exp=0", count_clr); end
    press_end();
    press_begin(1'b0, 1'b1);
    tick = 1'b1; #1;
    checks++; if (state !== IDLE) begin errors++; $display("FAIL clr_stop_idle got=%0d exp=%0d", state, IDLE); end
    checks++; if (count_clr !== 1'b1) begin errors++; $display("FAIL clr_stop_pulse got=%b exp=1", count_clr); end
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL clr_excl_en got=%b exp=0", count_en); end
    @(negedge clk); tick = 1'b0;
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL clr_stop_width got=%b exp=0", count_clr); end
    press_end();
    press_begin(1'b0, 1'b1);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL clr_idle_stay got=%0d exp=%0d", state, IDLE); end
    checks++; if (count_clr !== 1'b1) begin errors++; $display("FAIL clr_idle_pulse got=%b exp=1", count_clr); end
    @(negedge clk);
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL clr_idle_width got=%b exp=0", count_clr); end
    press_end();
  endtask

  task automatic test_simultaneous_and_reset();
    press_begin(1'b1, 1'b0);
    checks++; if (state !== RUN) begin errors++; $display("FAIL sim_pre_run got=%0d exp=%0d", state, RUN); end
    press_end();
    press_begin(1'b1, 1'b1);
    checks++; if (state !== STOP) begin errors++; $display("FAIL sim_start_wins got=%0d exp=%0d", state, STOP); end
    checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL sim_hold got=%b exp=0", display_hold); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL sim_no_clr got=%b exp=0", count_clr); end
    @(negedge clk);
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL sim_no_clr_late got=%b exp=0", count_clr); end
    press_end();
    press_begin(1'b1, 1'b0);
    press_end();
    press_begin(1'b0, 1'b1);
    checks++; if (state !== LAP) begin errors++; $display("FAIL rst_pre_lap got=%0d exp=%0d", state, LAP); end
    // Reset lands mid-cycle; outputs must drop without a clock edge.
    #2 reset_n = 1'b0; tick = 1'b1; #1;
    checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_async_state got=%0d exp=%0d", state, IDLE); end
    checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL rst_async_hold got=%b exp=0", display_hold); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_async_running got=%b exp=0", running); end
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL rst_async_count_en got=%b exp=0", count_en); end
    tick = 1'b0;
    lap_n = 1'b1;
    button_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_held_no_event got=%0d exp=%0d", state, IDLE); end
    button_n = 1'b1;
    repeat (N + 6) @(negedge clk);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_release_no_event got=%0d exp=%0d", state, IDLE); end
    press_begin(1'b1, 1'b0);
    checks++; if (state !== RUN) begin errors++; $display("FAIL rst_repress_run got=%0d exp=%0d", state, RUN); end
    press_end();
  endtask

  task automatic test_long_press();
    int clr_seen;
    int exp_clr;
    clr_seen = 0;
    press_begin(1'b1, 1'b0);
    checks++; if (state !== STOP) begin errors++; $display("FAIL long_stop got=%0d exp=%0d", state, STOP); end
    repeat (LP - 2) @(negedge clk);
    checks++; if (state !== STOP) begin errors++; $display("FAIL long_before got=%0d exp=%0d", state, STOP); end
    @(negedge clk);
`ifdef STOPWATCH_LONG_PRESS_CLEAR_EN
    checks++; if (state !== IDLE) begin errors++; $display("FAIL long_idle got=%0d exp=%0d", state, IDLE); end
    checks++; if (count_clr !== 1'b1) begin errors++; $display("FAIL long_clr got=%b exp=1", count_clr); end
    exp_clr = 1;
`else
    checks++; if (state !== STOP) begin errors++; $display("FAIL long_stays_stop got=%0d exp=%0d", state, STOP); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL long_no_clr got=%b exp=0", count_clr); end
    exp_clr = 0;
`endif
    if (count_clr === 1'b1) clr_seen++;
    // Keep holding to 100 press cycles, then release and settle.
    for (int i = 0; i < 100 - LAT - (LP - 1) + N + 4; i++) begin
      if (i == 100 - LAT - (LP - 1)) button_n = 1'b1;
      @(negedge clk);
      if (count_clr === 1'b1) clr_seen++;
    end
    checks++; if (clr_seen !== exp_clr) begin errors++; $display("FAIL long_clr_count got=%0d exp=%0d", clr_seen, exp_clr); end
`ifdef STOPWATCH_LONG_PRESS_CLEAR_EN
    checks++; if (state !== IDLE) begin errors++; $display("FAIL long_final got=%0d exp=%0d", state, IDLE); end
`else
    checks++; if (state !== STOP) begin errors++; $display("FAIL long_final got=%0d exp=%0d", state, STOP); end
`endif
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_lap();
    test_clear();
    test_simultaneous_and_reset();
    test_long_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control sequencer for the stopwatch datapath. It sits between the raw pushbuttons and the BCD digit counter. It synchronizes and debounces the start/stop and lap/clear buttons and runs a four-state run/stop/lap FSM. It gates the 10 Hz tick into a count enable, issues clear pulses, and tells the display path to hold (freeze) the shown value during a lap.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles a button level must be stable before it is accepted (10 ms at 100 MHz); must be >= 2
LONG_PRESS_CYCLES, 200000000, clk cycles of continuous start-button press that triggers clear (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
button_n  input  1  start/stop pushbutton, active-low, asynchronous to clk
lap_n  input  1  lap/clear pushbutton, active-low, asynchronous to clk
tick  input  1  one-clk-wide 10 Hz count strobe from the clock generator, synchronous to clk
count_en  output  1  counter increment enable; one clk wide
count_clr  output  1  counter synchronous clear; one-clk pulse
display_hold  output  1  1 = display path latches and shows the frozen value
running  output  1  1 in RUN or LAP
state  output  2  current FSM state, for debug LEDs

Behaviour:
- Reset: async assert, sync release. state=IDLE, count_clr=0, display_hold=0, running=0. Synchronizers, debounced levels (released=1) and counters are cleared.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clk; the counter restarts on any bounce.
  - A press event is a 1-clk pulse on the debounced 1->0 transition. Release generates no event.
- Latency: press event asserts DEBOUNCE_CYCLES+3 clk after a clean button edge (±1 clk). The FSM updates on the next clk edge.
- FSM (2-bit state):
  - IDLE: start -> RUN. lap -> issue count_clr pulse, stay IDLE.
  - RUN: start -> STOP. lap -> LAP (display_hold=1).
  - LAP: lap -> RUN (display_hold=0). start -> STOP (display_hold=0).
  - STOP: start -> RUN. lap -> IDLE and issue count_clr pulse.
- Simultaneous start and lap events in the same clk: start wins, lap is discarded.
- count_en = tick AND (state==RUN or LAP). It is combinational from the state register and tick, so counting continues during LAP. A tick in the same cycle as a transition uses the pre-transition state.
- count_clr: registered; high exactly 1 clk, the cycle after the clearing event. It is never asserted while count_en is 1.
- display_hold: registered, equal to (state==LAP).
- running: registered, equal to (state==RUN or LAP).
- A button held indefinitely produces exactly one event.
- reset_n asserted mid-debounce or mid-LAP: immediate return to reset values. A button still held at reset release generates no event until it is released and pressed again.

Optional Feature:
STOPWATCH_LONG_PRESS_CLEAR_EN
- Defined:
  - A separate counter times continuous debounced press of button_n.
  - On reaching LONG_PRESS_CYCLES, in any state, the FSM goes to IDLE, pulses count_clr for 1 clk and clears display_hold.
  - The counter saturates, so there is one clear per hold.
  - The normal short-press start event still occurs at press start. A long press from RUN therefore goes RUN->STOP->IDLE.
- Undefined: no long-press logic. LONG_PRESS_CYCLES is unused, and only lap in STOP/IDLE clears.

Decomposition:
- Shared package stopwatch_pkg:
  - typedef sw_state_t: IDLE=2'd0, RUN=2'd1, LAP=2'd2, STOP=2'd3.
  - Constant TICK_HZ=10.
  - The state port encoding comes from this typedef.
- One sub-module, button_debounce, instantiated twice: synchronizer, stability counter of width $clog2(DEBOUNCE_CYCLES+1), debounced level, press pulse.
- FSM, tick gating and long-press timer live in stopwatch_ctrl.

Test Plan:
1. DEBOUNCE_CYCLES=4; reset, press button_n cleanly 20 clk -> one event; state IDLE->RUN; with tick every 10 clk, count_en pulses coincide with tick; running=1.
2. button_n bouncing 1/0 every 2 clk for 12 clk, then held low -> no event during bounce; exactly one event 4+3 clk after the final stable low; state RUN->STOP; count_en stays 0 on later ticks.
3. In RUN, press lap_n -> state=LAP, display_hold=1 next clk, count_en still follows tick; press lap_n again -> RUN, display_hold=0.
4. In STOP, press lap_n -> count_clr high exactly 1 clk, state=IDLE; press lap_n in IDLE -> second single count_clr pulse, state stays IDLE.
5. Force start and lap events in the same clk while in RUN -> state=STOP, display_hold=0, no count_clr; assert reset_n mid-LAP -> all outputs 0, state=IDLE asynchronously.
6. STOPWATCH_LONG_PRESS_CLEAR_EN defined, LONG_PRESS_CYCLES=50; in RUN, hold button_n 100 clk -> RUN->STOP at press, then IDLE with a single count_clr at 50 stable-press clk. Without the macro, the same stimulus ends in STOP with no count_clr.
